// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NUM_REQ producers, with bursts of up to BURST_LEN words.
// Optional stall counter port stall_cnt is enabled by defining FIFO_ARB_STATS_EN.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int D_SIZE    = 8,
  parameter int BURST_LEN = 4,
  localparam int IDW      = $clog2(NUM_REQ)
) (
  input  logic                      wclk,
  input  logic                      wrst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*D_SIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ack,
  input  logic                      wfull,
  output logic                      winc,
  output logic [D_SIZE-1:0]         wdata,
  output logic [IDW-1:0]            gnt_id,
  output logic                      busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [15:0]               stall_cnt
`endif
);

  localparam int BCW = $clog2(BURST_LEN) + 1;
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BURST_LEN - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   gnt_id_q, gnt_id_d;
  logic [BCW-1:0]   burst_cnt_q, burst_cnt_d;

  logic [D_SIZE-1:0] reqWord [NUM_REQ];
  logic [IDW-1:0]    cand;
  logic [IDW-1:0]    pickIdx;
  logic              pickValid;
  logic [IDW-1:0]    nextPtr;
  logic              heldReq;
  logic              accept;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign reqWord[i] = req_data[i*D_SIZE +: D_SIZE];
  end

  // Search from rr_ptr upward, wrapping explicitly so non-power-of-two NUM_REQ works.
  always_comb begin
    pickValid = 1'b0;
    pickIdx   = rr_ptr_q;
    cand      = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pickValid && req[cand]) begin
        pickValid = 1'b1;
        pickIdx   = cand;
      end
      cand = (cand == LAST_ID) ? '0 : cand + 1'b1;
    end
  end

  assign heldReq = req[gnt_id_q];
  assign accept  = (state_q == GRANT) && heldReq && !wfull;
  assign nextPtr = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_id_d    = gnt_id_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pickValid) begin
          state_d     = GRANT;
          gnt_id_d    = pickIdx;
          burst_cnt_d = '0;
        end
      end
      GRANT: begin
        if (accept) begin
          if (burst_cnt_q == LAST_BEAT) begin
            state_d  = IDLE;
            rr_ptr_d = nextPtr;
          end else begin
            burst_cnt_d = burst_cnt_q + 1'b1;
          end
        end else if (!heldReq) begin
          state_d  = IDLE;
          rr_ptr_d = nextPtr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ack = '0;
    if (accept) begin
      req_ack[gnt_id_q] = 1'b1;
    end
    winc   = accept;
    wdata  = reqWord[gnt_id_q];
    gnt_id = gnt_id_q;
    busy   = (state_q == GRANT);
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gnt_id_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_id_q    <= gnt_id_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] stall_cnt_q;

  // Counts back-pressure cycles seen by the grant holder; saturates rather than wrapping.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      stall_cnt_q <= '0;
    end else if ((state_q == GRANT) && heldReq && wfull && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
